// File: rtl/mcu_pixel_packer_pkg.sv
// Shared encodings for the MCU pixel packer: input modes, assembly phases, pixel width.
package mcu_pixel_packer_pkg;

  localparam int unsigned PIXEL_WIDTH = 12;

  localparam logic [1:0] MODE_RGB444_2B     = 2'd0;
  localparam logic [1:0] MODE_RGB332        = 2'd1;
  localparam logic [1:0] MODE_RGB444_PACKED = 2'd2;
  localparam logic [1:0] MODE_RESERVED      = 2'd3;

  typedef enum logic [1:0] {
    PhaseP0 = 2'd0,
    PhaseP1 = 2'd1,
    PhaseP2 = 2'd2
  } phase_e;

  // Widen RGB332 to RGB444 by replicating each channel's top bit(s) into the low bits.
  function automatic logic [PIXEL_WIDTH-1:0] rgb332_to_444(input logic [7:0] b);
    return {b[7:5], b[7], b[4:2], b[4], b[1:0], b[1:0]};
  endfunction

endpackage

// File: rtl/mcu_pixel_packer_pixel_queue.sv
// Synchronous first-word-fall-through ring buffer; head is visible combinationally.
module mcu_pixel_packer_pixel_queue #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              do_push, do_pop;

  assign full  = (level_q == LevelW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // Pops on an empty queue are ignored; a full queue accepts a push only alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty queue presents zero so the output is clean after reset.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mcu_pixel_packer.sv
// Assembles MCU bytes into RGB444 pixels in one of three formats and queues them.
module mcu_pixel_packer
  import mcu_pixel_packer_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH = 4,
  parameter int unsigned LINE_PIXELS  = 640,
  parameter int unsigned COL_WIDTH    = 10
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            byte_valid,
  input  logic [7:0]                      byte_data,
  input  logic                            mode_load,
  input  logic [1:0]                      mode_in,
  input  logic                            clear_status,
  output logic                            pixel_valid,
  output logic [PIXEL_WIDTH-1:0]          pixel_data,
  output logic                            pixel_last,
  input  logic                            pixel_ready,
  output logic [$clog2(BUFFER_DEPTH):0]   level,
  output logic                            overflow,
  output logic                            bad_mode
);

  logic [1:0]             mode_q;
  phase_e                 phase_q;
  logic [7:0]             hold_q;
  logic [COL_WIDTH-1:0]   column_q;
  logic                   overflow_q, bad_mode_q;

  logic                   push_req;
  logic [PIXEL_WIDTH-1:0] push_pixel;
  logic                   col_last;
  logic                   q_full, q_empty;
  logic                   pop;
  logic                   overflow_event, bad_event;
  logic [PIXEL_WIDTH:0]   head;

  assign col_last = (column_q == COL_WIDTH'(LINE_PIXELS - 1));
  assign pop      = !q_empty && pixel_ready;

  // Decide whether the incoming byte completes a pixel, and what that pixel is.
  always_comb begin
    push_req   = 1'b0;
    push_pixel = '0;
    if (byte_valid && !mode_load) begin
      case (mode_q)
        MODE_RGB444_2B: begin
          if (phase_q == PhaseP1) begin
            push_req   = 1'b1;
            push_pixel = {hold_q, byte_data[3:0]};
          end
        end
        MODE_RGB332: begin
          push_req   = 1'b1;
          push_pixel = rgb332_to_444(byte_data);
        end
        MODE_RGB444_PACKED: begin
          if (phase_q == PhaseP1) begin
            push_req   = 1'b1;
            push_pixel = {hold_q, byte_data[7:4]};
          end else if (phase_q == PhaseP2) begin
            push_req   = 1'b1;
            push_pixel = {hold_q[3:0], byte_data};
          end
        end
        default: ;
      endcase
    end
  end

  assign overflow_event = push_req && q_full && !pop;
  assign bad_event      = byte_valid && !mode_load && (mode_q == MODE_RESERVED);

  // Phase FSM with mode, hold byte, column counter and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q     <= MODE_RGB444_2B;
      phase_q    <= PhaseP0;
      hold_q     <= '0;
      column_q   <= '0;
      overflow_q <= 1'b0;
      bad_mode_q <= 1'b0;
    end else begin
      if (mode_load) begin
        mode_q   <= mode_in;
        phase_q  <= PhaseP0;
        hold_q   <= '0;
        column_q <= '0;
      end else if (byte_valid) begin
        // Column advances even when the pixel is dropped, keeping line alignment.
        if (push_req) column_q <= col_last ? '0 : column_q + 1'b1;
        case (mode_q)
          MODE_RGB444_2B: begin
            if (phase_q == PhaseP0) begin
              hold_q  <= byte_data;
              phase_q <= PhaseP1;
            end else begin
              phase_q <= PhaseP0;
            end
          end
          MODE_RGB444_PACKED: begin
            case (phase_q)
              PhaseP0: begin
                hold_q  <= byte_data;
                phase_q <= PhaseP1;
              end
              PhaseP1: begin
                hold_q  <= {hold_q[7:4], byte_data[3:0]};
                phase_q <= PhaseP2;
              end
              default: phase_q <= PhaseP0;
            endcase
          end
          default: phase_q <= PhaseP0;
        endcase
      end
      // A new error event outranks a simultaneous clear.
      overflow_q <= overflow_event | (overflow_q & ~clear_status);
      bad_mode_q <= bad_event | (bad_mode_q & ~clear_status);
    end
  end

  mcu_pixel_packer_pixel_queue #(
    .WIDTH (PIXEL_WIDTH + 1),
    .DEPTH (BUFFER_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data ({col_last, push_pixel}),
    .pop       (pixel_ready),
    .head_data (head),
    .level     (level),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign pixel_valid = !q_empty;
  assign pixel_data  = head[PIXEL_WIDTH-1:0];
  assign pixel_last  = head[PIXEL_WIDTH];
  assign overflow    = overflow_q;
  assign bad_mode    = bad_mode_q;

endmodule
